// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_MEM_LAT = 1;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Requester selection: fixed data priority, or round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
`endif
  input  logic i_req,
  input  logic d_req,
  output logic pick_i,
  output logic pick_d
);

`ifdef MEM_ARB_RR_EN
  req_id_e last_q, last_d;

  // Pointer starts at data so the first conflict goes to the instruction port.
  always_comb begin
    last_d = last_q;
    pick_i = i_req && (!d_req || (last_q == REQ_D));
    pick_d = d_req && !pick_i;
    if (grant_en && pick_i) begin
      last_d = REQ_I;
    end else if (grant_en && pick_d) begin
      last_d = REQ_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= REQ_D;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
    pick_i = i_req && !d_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single fixed-latency memory, one access in flight.
// Optional round-robin conflict resolution via MEM_ARB_RR_EN.
//
// state | meaning
// IDLE  | no access in flight; grants given combinationally
// ISSUE | m_en pulsed with latched fields; latency counter loaded
// WAIT  | counting down MEM_LAT cycles; m_rdata captured on the last one
// RESP  | winner's rvalid pulsed with captured data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(MEM_LAT);

  state_e              state_q, state_d;
  req_id_e             id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                pick_i, pick_d;
  logic                grant_fire;
  logic                capture;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk      (clk),
    .reset    (reset),
    .grant_en (state_q == IDLE),
`endif
    .i_req    (i_req),
    .d_req    (d_req),
    .pick_i   (pick_i),
    .pick_d   (pick_d)
  );

  assign grant_fire = (state_q == IDLE) && (pick_i || pick_d);
  assign capture    = (state_q == WAIT) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_en    = 1'b0;
    m_we    = 1'b0;
    case (state_q)
      IDLE: begin
        // Grants are masked while reset is asserted so all outputs read 0.
        i_gnt = reset && pick_i;
        d_gnt = reset && pick_d;
        if (pick_i || pick_d) state_d = ISSUE;
      end
      ISSUE: begin
        m_en    = 1'b1;
        m_we    = we_q;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      id_q      <= REQ_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        id_q   <= pick_d ? REQ_D : REQ_I;
        addr_q <= pick_d ? d_addr : i_addr;
        we_q   <= pick_d && d_we;
        be_q   <= pick_d ? d_be : '1;
        if (pick_d) wdata_q <= d_wdata;
      end
      if (state_q == ISSUE) begin
        cnt_q <= LAT_LD;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // Writes complete with zero read data.
      if (capture) begin
        if (id_q == REQ_I) begin
          i_rdata_q <= m_rdata;
        end else begin
          d_rdata_q <= we_q ? '0 : m_rdata;
        end
      end
    end
  end

  assign i_rvalid = (state_q == RESP) && (id_q == REQ_I);
  assign d_rvalid = (state_q == RESP) && (id_q == REQ_D);
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign m_be     = be_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance A (MEM_LAT=1) and instance B (MEM_LAT=3).
module tb_mem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef MEM_ARB_RR_EN
  localparam bit FIRST_D = 1'b0;
`else
  localparam bit FIRST_D = 1'b1;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
  } iss_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A signals
  logic        a_i_req = 1'b0, a_i_gnt, a_i_rvalid;
  logic [31:0] a_i_addr = '0, a_i_rdata;
  logic        a_d_req = 1'b0, a_d_we = 1'b0, a_d_gnt, a_d_rvalid;
  logic [3:0]  a_d_be = '0;
  logic [31:0] a_d_addr = '0, a_d_wdata = '0, a_d_rdata;
  logic        a_m_en, a_m_we, a_busy;
  logic [3:0]  a_m_be;
  logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;

  // instance B signals
  logic        b_i_req = 1'b0, b_i_gnt, b_i_rvalid;
  logic [31:0] b_i_addr = '0, b_i_rdata;
  logic        b_d_req = 1'b0, b_d_we = 1'b0, b_d_gnt, b_d_rvalid;
  logic [3:0]  b_d_be = '0;
  logic [31:0] b_d_addr = '0, b_d_wdata = '0, b_d_rdata;
  logic        b_m_en, b_m_we, b_busy;
  logic [3:0]  b_m_be;
  logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A)) u_dut_a (
    .clk(clk), .reset(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .m_en(a_m_en), .m_we(a_m_we), .m_be(a_m_be), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_rdata(a_m_rdata), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B)) u_dut_b (
    .clk(clk), .reset(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .m_en(b_m_en), .m_we(b_m_we), .m_be(b_m_be), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_rdata(b_m_rdata), .busy(b_busy)
  );

  // memory model: read data is valid only in the single cycle MEM_LAT after m_en
  logic [31:0] mem [logic [31:0]];
  logic [31:0] a_w;
  logic [31:0] a_rd_word = '0, b_rd_word = '0;
  logic        a_pend = 1'b0, b_pend = 1'b0;
  int          a_en_cyc = 0, b_en_cyc = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hEEEE_EEEE;
  endfunction

  always @(posedge clk) begin
    if (a_m_en) begin
      if (a_m_we) begin
        a_w = mem_rd(a_m_addr);
        for (int k = 0; k < 4; k++) if (a_m_be[k]) a_w[8*k +: 8] = a_m_wdata[8*k +: 8];
        mem[a_m_addr] = a_w;
      end else begin
        a_rd_word <= mem_rd(a_m_addr);
        a_en_cyc  <= cyc;
        a_pend    <= 1'b1;
      end
    end
    if (b_m_en && !b_m_we) begin
      b_rd_word <= mem_rd(b_m_addr);
      b_en_cyc  <= cyc;
      b_pend    <= 1'b1;
    end
  end

  assign a_m_rdata = (a_pend && cyc == a_en_cyc + LAT_A) ? a_rd_word : 32'hDEAD_BEEF;
  assign b_m_rdata = (b_pend && cyc == b_en_cyc + LAT_B) ? b_rd_word : 32'hDEAD_BEEF;

  iss_t  iq[$];
  resp_t rq[$];
  resp_t qb[$];
  iss_t  ie;
  resp_t re, rb;
  int    b_busy_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor A
  always @(negedge clk) begin
    if (a_m_en) begin
      if (iq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_m_en: got m_addr 0x%0h expected no access", a_m_addr);
      end else begin
        ie = iq.pop_front();
        chk("m_en_cycle", 64'(cyc), 64'(ie.cyc));
        chk("m_addr", 64'(a_m_addr), 64'(ie.addr));
        chk("m_we", 64'(a_m_we), 64'(ie.we));
        chk("m_be", 64'(a_m_be), 64'(ie.be));
        if (ie.we) chk("m_wdata", 64'(a_m_wdata), 64'(ie.wdata));
      end
    end
    if (a_i_rvalid || a_d_rvalid) begin
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rvalid: got i_rvalid %0b d_rvalid %0b expected none", a_i_rvalid, a_d_rvalid);
      end else begin
        re = rq.pop_front();
        chk("rvalid_port", {62'd0, a_i_rvalid, a_d_rvalid}, {62'd0, !re.is_d, re.is_d});
        chk("rdata", 64'(a_d_rvalid ? a_d_rdata : a_i_rdata), 64'(re.data));
        chk("rvalid_cycle", 64'(cyc), 64'(re.cyc));
      end
    end
  end

  // monitor B
  always @(negedge clk) begin
    if (b_busy) b_busy_cnt++;
    if (b_i_rvalid || b_d_rvalid) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_rvalid: got i %0b d %0b expected none", b_i_rvalid, b_d_rvalid);
      end else begin
        rb = qb.pop_front();
        chk("b_rvalid_port", 64'(b_i_rvalid), 64'(1));
        chk("b_rdata", 64'(b_i_rdata), 64'(rb.data));
        chk("b_rvalid_cycle", 64'(cyc), 64'(rb.cyc));
      end
    end
  end

  task automatic expect_access(input logic use_d, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp, input int gcyc, input bit want_resp);
    iss_t  e;
    resp_t r;
    e.addr  = addr;
    e.we    = use_d & we;
    e.be    = use_d ? be : 4'hF;
    e.wdata = wdata;
    e.cyc   = gcyc + 1;
    iq.push_back(e);
    if (want_resp) begin
      r.is_d = use_d;
      r.data = exp;
      r.cyc  = gcyc + 2 + LAT_A;
      rq.push_back(r);
    end
  endtask

  // call right after a negedge with req already driven
  task automatic wait_gnt(input logic use_d, output int gcyc, output logic ok);
    ok   = 1'b0;
    gcyc = -1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (use_d ? a_d_gnt : a_i_gnt) begin
        ok   = 1'b1;
        gcyc = cyc;
        chk("gnt_exclusive", 64'(use_d ? a_i_gnt : a_d_gnt), 64'(0));
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL gnt_timeout: got no grant for %s port expected grant within 40 cycles", use_d ? "data" : "instr");
    end
  endtask

  task automatic drop_reqs();
    a_i_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_be = 4'h0;
    a_i_addr = 32'hFFFF_FFFF; a_d_addr = 32'hFFFF_FFFF; a_d_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic do_access(input logic use_d, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp, input bit want_resp);
    int   g;
    logic ok;
    @(negedge clk);
    if (use_d) begin
      a_d_req = 1'b1; a_d_we = we; a_d_be = be; a_d_addr = addr; a_d_wdata = wdata;
    end else begin
      a_i_req = 1'b1; a_i_addr = addr;
    end
    wait_gnt(use_d, g, ok);
    if (ok) expect_access(use_d, we, be, addr, wdata, exp, g, want_resp);
    @(negedge clk);
    drop_reqs();
  endtask

  initial begin : main
    int   t0, g;
    logic ok;
    mem[32'h0000_3000] = 32'hCAFE_0001;
    mem[32'h0000_0004] = 32'h1111_2222;
    mem[32'h0000_0040] = 32'h5A5A_0033;
    mem[32'h0000_0100] = 32'h0BAD_0100;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(a_busy), 64'(0));
    chk("rst_m_en", 64'(a_m_en), 64'(0));
    chk("rst_outputs", {a_i_rdata, a_d_rdata}, 64'(0));
    chk("rst_mem_side", {a_m_addr, a_m_be, a_m_we, 28'd0}, 64'(0));
    rst = 1'b1;

    // conflict from IDLE right after reset
    @(negedge clk);
    a_i_req = 1'b1; a_i_addr = 32'h0000_3000;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_be = 4'hF; a_d_addr = 32'h0000_0100;
    #1;
    chk("conflict_first_d_gnt", 64'(a_d_gnt), 64'(FIRST_D));
    chk("conflict_first_i_gnt", 64'(a_i_gnt), 64'(!FIRST_D));
    t0 = cyc;
    if (FIRST_D) expect_access(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0BAD_0100, t0, 1'b1);
    else         expect_access(1'b0, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 32'hCAFE_0001, t0, 1'b1);
    @(negedge clk);
    if (FIRST_D) a_d_req = 1'b0;
    else         a_i_req = 1'b0;
    wait_gnt(!FIRST_D, g, ok);
    chk("conflict_spacing", 64'(g - t0), 64'(4));
    if (FIRST_D) expect_access(1'b0, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 32'hCAFE_0001, g, 1'b1);
    else         expect_access(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0BAD_0100, g, 1'b1);
    @(negedge clk);
    drop_reqs();

    // single read, write, read-back through both ports
    do_access(1'b0, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 32'hCAFE_0001, 1'b1);
    do_access(1'b1, 1'b1, 4'b0011, 32'h0000_0004, 32'h1234_5678, 32'h0, 1'b1);
    do_access(1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'h1111_5678, 1'b1);
    do_access(1'b0, 1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'h1111_5678, 1'b1);
    repeat (6) @(negedge clk);
    chk("hold_d_rdata", 64'(a_d_rdata), 64'(32'h1111_5678));
    chk("hold_i_rdata", 64'(a_i_rdata), 64'(32'h1111_5678));
    chk("hold_m_addr", 64'(a_m_addr), 64'(32'h0000_0004));

    // reset during WAIT discards the response
    do_access(1'b0, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("wait_busy", 64'(a_busy), 64'(1));
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {58'd0, a_i_gnt, a_d_gnt, a_i_rvalid, a_d_rvalid, a_m_en, a_m_we}, 64'(0));
    chk("midrst_busy", 64'(a_busy), 64'(0));
    chk("midrst_rdata", {a_i_rdata, a_d_rdata}, 64'(0));
    chk("midrst_m_addr", 64'(a_m_addr), 64'(0));
    chk("midrst_m_wdata_be", {a_m_wdata, a_m_be, 28'd0}, 64'(0));
    rst = 1'b1;
    repeat (3) @(negedge clk);
    do_access(1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'h5A5A_0033, 1'b1);
    repeat (6) @(negedge clk);

    // latency with MEM_LAT=3
    @(negedge clk);
    b_i_req = 1'b1; b_i_addr = 32'h0000_0040;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (b_i_gnt) begin
        ok = 1'b1;
        rb.is_d = 1'b0; rb.data = 32'h5A5A_0033; rb.cyc = cyc + 2 + LAT_B;
        qb.push_back(rb);
        b_busy_cnt = 0;
        break;
      end
      @(negedge clk);
    end
    chk("b_gnt_seen", 64'(ok), 64'(1));
    @(negedge clk);
    b_i_req = 1'b0; b_i_addr = 32'hFFFF_FFFF;
    repeat (10) @(negedge clk);
    chk("b_busy_len", 64'(b_busy_cnt), 64'(5));

    chk("drain_iq", 64'(iq.size()), 64'(0));
    chk("drain_rq", 64'(rq.size()), 64'(0));
    chk("drain_qb", 64'(qb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    tests++; fails++;
    $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; byte enables are DATA_W/8 bits.
REQ-003 SHALL have parameter MEM_LAT, default 1, legal 1..15, meaning cycles from m_en to valid m_rdata.
REQ-004 SHALL have ports: clk input 1 system clock; reset input 1 synchronous active-low reset (0 = reset).
REQ-005 SHALL have instruction-port ports: i_req in 1; i_addr in ADDR_W; i_gnt out 1; i_rvalid out 1; i_rdata out DATA_W.
REQ-006 SHALL have data-port ports: d_req in 1; d_we in 1; d_be in DATA_W/8; d_addr in ADDR_W; d_wdata in DATA_W; d_gnt out 1; d_rvalid out 1; d_rdata out DATA_W.
REQ-007 SHALL have memory-side ports: m_en out 1; m_we out 1; m_be out DATA_W/8; m_addr out ADDR_W; m_wdata out DATA_W; m_rdata in DATA_W; and busy out 1 (state != IDLE).

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one access outstanding at most.
REQ-009 SHALL, in IDLE only, assert exactly one of i_gnt/d_gnt combinationally when its req is high; no grant in other states.
REQ-010 SHALL latch winner id, address, we, be, wdata on the grant edge; requester holds req/address until gnt and may drop req afterwards.
REQ-011 SHALL drive m_en=1 for exactly the one ISSUE cycle with latched fields; instruction accesses drive m_we=0, m_be all-ones.
REQ-012 SHALL stay in WAIT exactly MEM_LAT cycles via down-counter loaded MEM_LAT in ISSUE; capture m_rdata at the end of the last WAIT cycle.
REQ-013 SHALL in RESP pulse the winner's rvalid for one cycle with captured data; writes also pulse rvalid with rdata=0.
REQ-014 SHALL give latency: gnt cycle T, m_en at T+1, rvalid at T+2+MEM_LAT; minimum grant spacing MEM_LAT+3 cycles.
REQ-015 SHALL, on simultaneous i_req and d_req in IDLE, grant data (fixed priority) unless REQ-020 applies; instruction starvation under continuous d_req is accepted behaviour.
REQ-016 SHALL hold rdata outputs at last delivered value when rvalid=0; m_addr/m_wdata/m_be hold last values outside ISSUE.
REQ-017 SHALL ignore requests arriving in non-IDLE states; they are granted in the next IDLE cycle if still asserted.
REQ-018 SHALL pass addresses unmodified; no alignment check.

Reset
REQ-019 SHALL, on reset=0 at a clk edge (including mid-access), go to IDLE, discard any in-flight response, and set i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, busy to 0 and i_rdata, d_rdata, m_addr, m_wdata, m_be, counter to 0.

Configuration
REQ-020 SHALL, with macro MEM_ARB_RR_EN defined, resolve conflicts round-robin: the port not granted last wins; last-grant pointer resets to data so the first conflict goes to instruction; without the macro, fixed data priority per REQ-015 and no pointer register.

Structure
REQ-021 SHALL place state enum (IDLE, ISSUE, WAIT, RESP), requester id enum (REQ_I, REQ_D) and default widths in package mem_arb_pkg.
REQ-022 SHALL isolate arbitration selection (fixed or round-robin) in sub-module mem_arb_pick.

Verification
REQ-023 SHALL test single read: MEM_LAT=1, i_req with i_addr=0x3000 at T -> i_gnt at T, m_en at T+1 with m_addr=0x3000, i_rvalid at T+3 with i_rdata = memory word.
REQ-024 SHALL test write: d_req, d_we=1, d_be=4'b0011, d_addr=0x0004, d_wdata=0x12345678 -> m_we=1, m_be=4'b0011 in ISSUE; d_rvalid with d_rdata=0.
REQ-025 SHALL test conflict: i_req and d_req both high from IDLE -> d_gnt first; i_gnt at T+4 (MEM_LAT=1); with MEM_ARB_RR_EN, i_gnt first, d_gnt next.
REQ-026 SHALL test latency: MEM_LAT=3 -> rvalid exactly 5 cycles after gnt; busy high for 5 cycles.
REQ-027 SHALL test reset mid-WAIT: reset=0 one cycle during WAIT -> no rvalid, all outputs 0 next cycle, fresh i_req granted after reset=1.
